// File: rtl/wb_retire_unit.sv
// Write-back/retire stage: load filtering, write-data select, registered RF write,
// saturating retire counter and halt FSM. Optional trace port: WB_RETIRE_TRACE_EN.
module wb_retire_unit #(
    parameter int BITS_SIZE = 32,
    parameter int BITS_REGS = 5,
    parameter int BITS_CNT  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_step,
    input  logic                 i_resume,
    input  logic [BITS_SIZE-1:0] i_pc8,
    input  logic [BITS_SIZE-1:0] i_instruction,
    input  logic [BITS_SIZE-1:0] i_alu,
    input  logic [BITS_SIZE-1:0] i_dato_mem,
    input  logic [BITS_REGS-1:0] i_register_rd_dst,
    input  logic [BITS_SIZE-1:0] i_extension,
    input  logic                 i_jal,
    input  logic                 i_lui,
    input  logic                 i_mem_to_reg,
    input  logic                 i_register_write,
    input  logic                 i_zero_extend,
    input  logic                 i_halt,
    input  logic [1:0]           i_size_filterL,
    output logic                 o_wr_enable,
    output logic [BITS_REGS-1:0] o_wr_addr,
    output logic [BITS_SIZE-1:0] o_wr_data,
    output logic [BITS_CNT-1:0]  o_retired_count,
`ifdef WB_RETIRE_TRACE_EN
    output logic                 o_trace_valid,
    output logic [BITS_SIZE-1:0] o_trace_instr,
    output logic [BITS_SIZE-1:0] o_trace_pc,
`endif
    output logic                 o_halted
);

    typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;

    state_t               state;
    logic [BITS_SIZE-1:0] load_data;
    logic [BITS_SIZE-1:0] sel_data;
    logic                 retire;
    logic                 counted;
    logic                 unused_ext;

    // lui only consumes the low half of the immediate
    assign unused_ext = ^i_extension[BITS_SIZE-1:16];

    assign retire  = (state == RUN) && i_step;
    assign counted = retire && (i_instruction != '0);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        load_data = i_dato_mem;
        case (i_size_filterL)
            2'b00: load_data = i_zero_extend
                ? {{(BITS_SIZE-8){1'b0}}, i_dato_mem[7:0]}
                : {{(BITS_SIZE-8){i_dato_mem[7]}}, i_dato_mem[7:0]};
            2'b01: load_data = i_zero_extend
                ? {{(BITS_SIZE-16){1'b0}}, i_dato_mem[15:0]}
                : {{(BITS_SIZE-16){i_dato_mem[15]}}, i_dato_mem[15:0]};
            default: load_data = i_dato_mem;
        endcase
    end

    always_comb begin
        sel_data = i_alu;
        if (i_jal)
            sel_data = i_pc8;
        else if (i_lui)
            sel_data = {i_extension[15:0], {(BITS_SIZE-16){1'b0}}};
        else if (i_mem_to_reg)
            sel_data = load_data;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state           <= RUN;
            o_halted        <= 1'b0;
            o_wr_enable     <= 1'b0;
            o_wr_addr       <= '0;
            o_wr_data       <= '0;
            o_retired_count <= '0;
        end else begin
            o_wr_enable <= retire && i_register_write && (i_register_rd_dst != '0) && !i_halt;
            if (retire) begin
                o_wr_addr <= i_register_rd_dst;
                o_wr_data <= sel_data;
            end
            if (counted && (o_retired_count != '1))
                o_retired_count <= o_retired_count + BITS_CNT'(1);

            case (state)
                RUN: begin
                    if (retire && i_halt)
                        state <= HALT_PEND;
                end
                HALT_PEND: begin
                    state    <= HALTED;
                    o_halted <= 1'b1;
                end
                HALTED: begin
                    if (i_resume) begin
                        state    <= RUN;
                        o_halted <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    o_halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_RETIRE_TRACE_EN
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_trace_valid <= 1'b0;
            o_trace_instr <= '0;
            o_trace_pc    <= '0;
        end else begin
            o_trace_valid <= counted;
            if (retire) begin
                o_trace_instr <= i_instruction;
                o_trace_pc    <= i_pc8 - BITS_SIZE'(8);
            end
        end
    end
`endif

endmodule
